// File: rtl/layer7_pixel_buffer.sv
// Layer-7 pixel buffer: stores one WIDTH x WIDTH image of feature vectors and serves row/column reads.
// Define LAYER7_PIXEL_PINGPONG_EN for two banks so the next image can be written while one is consumed.
module layer7_pixel_buffer #(
    parameter int WIDTH  = 5,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              pixel_store_done,
    input  logic              read_pixel_signal,
    input  logic [15:0]       read_row_addr,
    input  logic [15:0]       read_col_addr,
    output logic [DATA_W-1:0] input_data,
    output logic              rd_addr_err,
    input  logic              layer7_calculation_done
);
    localparam int DEPTH = WIDTH * WIDTH;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef LAYER7_PIXEL_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef enum logic {BANK_FREE = 1'b0, BANK_FULL = 1'b1} bank_state_t;

    bank_state_t       r_bank_state      [NB];
    bank_state_t       w_bank_state_next [NB];
    logic [AW-1:0]     r_wr_idx;
    logic [AW-1:0]     w_wr_idx_next;
    logic              r_wr_bank;
    logic              w_wr_bank_next;
    logic              r_rd_bank;
    logic              w_rd_bank_next;
    logic              r_rd_valid;
    logic              w_rd_valid_next;
    logic              r_store_done;
    logic              w_store_done_next;
    logic              w_wr_full;
    logic              w_rd_full;
    logic              w_accept;
    logic              w_release;
    logic              w_in_range;
    logic              w_rd_hit;
    logic [AW-1:0]     w_rd_addr;
    logic              r_sel_zero;
    logic              r_addr_err;
    logic [DATA_W-1:0] w_bank_q [NB];

    always_comb begin
        w_wr_full = 1'b0;
        w_rd_full = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (r_wr_bank == 1'(b) && r_bank_state[b] == BANK_FULL) w_wr_full = 1'b1;
            if (r_rd_bank == 1'(b) && r_bank_state[b] == BANK_FULL) w_rd_full = 1'b1;
        end
    end

    assign wr_ready  = ~w_wr_full;
    assign w_accept  = wr_valid & ~w_wr_full;
    assign w_release = layer7_calculation_done & r_rd_valid;

    // Range is judged on the raw 16-bit coordinates; the wrapped product only matters when in range.
    assign w_in_range = (read_row_addr < 16'(WIDTH)) && (read_col_addr < 16'(WIDTH));
    assign w_rd_hit   = read_pixel_signal & w_in_range & r_rd_valid;
    assign w_rd_addr  = AW'(read_row_addr * 16'(WIDTH) + read_col_addr);

    always_comb begin
        for (int b = 0; b < NB; b++) w_bank_state_next[b] = r_bank_state[b];
        w_wr_idx_next     = r_wr_idx;
        w_wr_bank_next    = r_wr_bank;
        w_rd_bank_next    = r_rd_bank;
        w_rd_valid_next   = r_rd_valid;
        w_store_done_next = 1'b0;

        if (w_accept) begin
            if (r_wr_idx == AW'(DEPTH - 1)) begin
                w_wr_idx_next = '0;
                for (int b = 0; b < NB; b++) begin
                    if (r_wr_bank == 1'(b)) w_bank_state_next[b] = BANK_FULL;
                end
`ifdef LAYER7_PIXEL_PINGPONG_EN
                w_wr_bank_next = ~r_wr_bank;
`endif
            end else begin
                w_wr_idx_next = r_wr_idx + 1'b1;
            end
        end

        // A release takes priority; any bank that is now full is announced on the following edge.
        if (w_release) begin
            for (int b = 0; b < NB; b++) begin
                if (r_rd_bank == 1'(b)) w_bank_state_next[b] = BANK_FREE;
            end
            w_rd_valid_next = 1'b0;
`ifdef LAYER7_PIXEL_PINGPONG_EN
            w_rd_bank_next = ~r_rd_bank;
`endif
        end else if (!r_rd_valid && w_rd_full) begin
            w_rd_valid_next   = 1'b1;
            w_store_done_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) r_bank_state[b] <= BANK_FREE;
            r_wr_idx     <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_store_done <= 1'b0;
        end else begin
            for (int b = 0; b < NB; b++) r_bank_state[b] <= w_bank_state_next[b];
            r_wr_idx     <= w_wr_idx_next;
            r_wr_bank    <= w_wr_bank_next;
            r_rd_bank    <= w_rd_bank_next;
            r_rd_valid   <= w_rd_valid_next;
            r_store_done <= w_store_done_next;
        end
    end

    assign pixel_store_done = r_store_done;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bank
            logic [DATA_W-1:0] r_mem [DEPTH];
            logic [DATA_W-1:0] r_q;

            always_ff @(posedge clk) begin
                if (w_accept && r_wr_bank == 1'(gi)) r_mem[r_wr_idx] <= wr_data;
                if (w_rd_hit && r_rd_bank == 1'(gi)) r_q <= r_mem[w_rd_addr];
            end

            assign w_bank_q[gi] = r_q;
        end
    endgenerate

    // The zero flag masks the RAM output for misses, so the RAM read port needs no reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_zero <= 1'b1;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= read_pixel_signal & ~w_in_range;
            if (read_pixel_signal) r_sel_zero <= ~w_rd_hit;
        end
    end

    assign rd_addr_err = r_addr_err;

`ifdef LAYER7_PIXEL_PINGPONG_EN
    logic r_sel_bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_bank <= 1'b0;
        end else if (read_pixel_signal) begin
            r_sel_bank <= r_rd_bank;
        end
    end

    assign input_data = r_sel_zero ? '0 : w_bank_q[r_sel_bank];
`else
    assign input_data = r_sel_zero ? '0 : w_bank_q[0];
`endif

endmodule

// File: tb/tb_layer7_pixel_buffer.sv
// Self-checking bench for layer7_pixel_buffer: directed steps plus random traffic against an image-queue model.
module tb_layer7_pixel_buffer;
    localparam int W     = 5;
    localparam int DW    = 128;
    localparam int DEPTH = W * W;
`ifdef LAYER7_PIXEL_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          pixel_store_done;
    logic          read_pixel_signal;
    logic [15:0]   read_row_addr;
    logic [15:0]   read_col_addr;
    logic [DW-1:0] input_data;
    logic          rd_addr_err;
    logic          layer7_calculation_done;

    layer7_pixel_buffer #(.WIDTH(W), .DATA_W(DW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .wr_valid                (wr_valid),
        .wr_data                 (wr_data),
        .wr_ready                (wr_ready),
        .pixel_store_done        (pixel_store_done),
        .read_pixel_signal       (read_pixel_signal),
        .read_row_addr           (read_row_addr),
        .read_col_addr           (read_col_addr),
        .input_data              (input_data),
        .rd_addr_err             (rd_addr_err),
        .layer7_calculation_done (layer7_calculation_done)
    );

    always #5 clk = ~clk;

    // Model: completed images queued oldest first (DEPTH words each), plus the image being written.
    logic [DW-1:0] m_full_q[$];
    logic [DW-1:0] m_part_q[$];
    bit            m_ann;
    logic          exp_ready, exp_done, exp_err;
    logic [DW-1:0] exp_data;
    int            errors = 0;
    int            checks = 0;
    int            done_cnt = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return m_full_q.size() < NB * DEPTH;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".wr_ready"}, wr_ready, exp_ready);
        chk({tag, ".store_done"}, pixel_store_done, exp_done);
        chk({tag, ".input_data"}, input_data, exp_data);
        chk({tag, ".rd_addr_err"}, rd_addr_err, exp_err);
    endtask

    task automatic tick(input string tag);
        bit            acc, rel, ann;
        logic [DW-1:0] d;
        int            r, c;
        acc = wr_valid && m_ready();
        rel = layer7_calculation_done && m_ann;
        ann = !m_ann && (m_full_q.size() > 0) && !rel;
        d   = wr_data;
        r   = int'(read_row_addr);
        c   = int'(read_col_addr);
        if (read_pixel_signal) begin
            if (r >= W || c >= W) begin
                exp_data = '0;
                exp_err  = 1'b1;
            end else begin
                exp_data = m_ann ? m_full_q[r * W + c] : '0;
                exp_err  = 1'b0;
            end
        end else begin
            exp_err = 1'b0;
        end
        @(posedge clk);
        if (acc) begin
            m_part_q.push_back(d);
            if (m_part_q.size() == DEPTH) begin
                foreach (m_part_q[i]) m_full_q.push_back(m_part_q[i]);
                m_part_q.delete();
            end
        end
        if (rel) begin
            repeat (DEPTH) void'(m_full_q.pop_front());
            m_ann = 0;
        end
        if (ann) m_ann = 1;
        exp_done  = ann;
        exp_ready = m_ready();
        #1;
        done_cnt += int'(pixel_store_done);
        check_all(tag);
        $display("t=%0t %s wv=%0b rd=%0b(%0d,%0d) rel=%0b -> ready=%0b done=%0b data=%0h err=%0b",
                 $time, tag, wr_valid, read_pixel_signal, read_row_addr, read_col_addr,
                 layer7_calculation_done, wr_ready, pixel_store_done, input_data, rd_addr_err);
    endtask

    task automatic write_one(input logic [DW-1:0] d, input string tag, output int stalls);
        bit acc;
        stalls   = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        do begin
            acc = m_ready();
            tick(tag);
            if (!acc) stalls++;
        end while (!acc && stalls < 200);
        chk({tag, ".accepted"}, acc, 1);
        wr_valid = 1'b0;
    endtask

    task automatic read_px(input int r, input int c, input string tag);
        read_pixel_signal = 1'b1;
        read_row_addr     = 16'(r);
        read_col_addr     = 16'(c);
        tick(tag);
        read_pixel_signal = 1'b0;
    endtask

    task automatic release_img(input string tag);
        layer7_calculation_done = 1'b1;
        tick(tag);
        layer7_calculation_done = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        wr_valid = 1'b0;
        read_pixel_signal = 1'b0;
        layer7_calculation_done = 1'b0;
        rst = 1'b1;
        #2;
        m_full_q.delete();
        m_part_q.delete();
        m_ann     = 0;
        exp_ready = 1'b1;
        exp_done  = 1'b0;
        exp_data  = '0;
        exp_err   = 1'b0;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required to end before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        int            st, tot, c0;
        logic [DW-1:0] v[50];
        logic [DW-1:0] first;

        wr_valid = 1'b0; wr_data = '0; read_pixel_signal = 1'b0;
        read_row_addr = '0; read_col_addr = '0; layer7_calculation_done = 1'b0;
        do_reset("reset");

        // Basic fill with 1..25, continuous.
        c0 = done_cnt; tot = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            write_one(DW'(i), "fill", st);
            tot += st;
        end
        chk("fill.stalls", DW'(tot), 0);
        chk("fill.done_at_next_cycle", DW'(done_cnt - c0), 0);
        tick("idle");
        chk("fill.done_pulse", pixel_store_done, 1);
        tick("idle");
        tick("idle");
        chk("fill.done_count", DW'(done_cnt - c0), 1);
        chk("fill.wr_ready_after", wr_ready, (NB == 1) ? 1'b0 : 1'b1);

        read_px(2, 3, "rd_2_3");
        chk("rd_2_3.value", input_data, 14);
        read_pixel_signal = 1'b1; read_row_addr = 16'd0; read_col_addr = 16'd0;
        tick("rd_0_0");
        chk("rd_0_0.value", input_data, 1);
        read_row_addr = 16'd4; read_col_addr = 16'd4;
        tick("rd_4_4");
        chk("rd_4_4.value", input_data, 25);
        read_row_addr = 16'd5; read_col_addr = 16'd0;
        tick("rd_5_0");
        chk("rd_5_0.value", input_data, 0);
        chk("rd_5_0.err", rd_addr_err, 1);
        read_pixel_signal = 1'b0;
        tick("rd_hold");
        chk("rd_hold.err_cleared", rd_addr_err, 0);

        release_img("release");
        chk("release.wr_ready", wr_ready, 1);
        read_px(1, 1, "rd_invalid");
        chk("rd_invalid.value", input_data, 0);
        chk("rd_invalid.err", rd_addr_err, 0);

        c0 = done_cnt;
        for (int i = 101; i <= 125; i++) write_one(DW'(i), "refill", st);
        tick("idle"); tick("idle");
        chk("refill.done_count", DW'(done_cnt - c0), 1);
        read_px(0, 0, "refill_rd");
        chk("refill_rd.value", input_data, 101);
        release_img("release");

`ifdef LAYER7_PIXEL_PINGPONG_EN
        // 50 back-to-back writes fill both banks without a stall.
        c0 = done_cnt; tot = 0;
        for (int i = 0; i < 50; i++) begin
            v[i] = {$urandom, $urandom, $urandom, $urandom};
            write_one(v[i], "pp_fill", st);
            tot += st;
        end
        tick("idle"); tick("idle");
        chk("pp_fill.stalls", DW'(tot), 0);
        chk("pp_fill.done_count", DW'(done_cnt - c0), 1);
        chk("pp_fill.wr_ready_full", wr_ready, 0);
        c0 = done_cnt;
        release_img("pp_release");
        tick("pp_announce");
        chk("pp_release.second_pulse", pixel_store_done, 1);
        read_px(0, 0, "pp_rd");
        chk("pp_rd.value", input_data, v[25]);

        // Last write of the next image coincides with the release of the current one.
        for (int i = 0; i < DEPTH - 1; i++) write_one(DW'(1000 + i), "pp_overlap", st);
        c0 = done_cnt;
        wr_valid = 1'b1; wr_data = DW'(1000 + DEPTH - 1);
        layer7_calculation_done = 1'b1;
        tick("pp_last_and_release");
        wr_valid = 1'b0; layer7_calculation_done = 1'b0;
        tick("pp_after");
        chk("pp_simul.pulse_next", pixel_store_done, 1);
        tick("idle"); tick("idle");
        chk("pp_simul.done_count", DW'(done_cnt - c0), 1);
        read_px(0, 0, "pp_simul_rd");
        chk("pp_simul_rd.value", input_data, 1000);
        release_img("pp_release");
        tick("idle");
`endif

        // Reset in the middle of a fill discards the partial image.
        for (int i = 0; i < 10; i++) write_one(DW'(500 + i), "pre_reset", st);
        do_reset("mid_reset");
        c0 = done_cnt;
        first = {$urandom, $urandom, $urandom, $urandom};
        write_one(first, "post_reset", st);
        for (int i = 1; i < DEPTH; i++) write_one({$urandom, $urandom, $urandom, $urandom}, "post_reset", st);
        tick("idle"); tick("idle");
        chk("post_reset.done_count", DW'(done_cnt - c0), 1);
        read_px(0, 0, "post_reset_rd");
        chk("post_reset_rd.value", input_data, first);
        release_img("release");

        // Random traffic, including 16-bit-wrapping coordinates and one random reset.
        for (int n = 0; n < 1500; n++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data  = {$urandom, $urandom, $urandom, $urandom};
            read_pixel_signal = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 9))
                0:       read_row_addr = 16'hFFFF;
                1:       read_row_addr = 16'd13108;
                default: read_row_addr = 16'($urandom_range(0, 5));
            endcase
            read_col_addr = ($urandom_range(0, 9) == 0) ? 16'd40000 : 16'($urandom_range(0, 5));
            layer7_calculation_done = ($urandom_range(0, 30) == 0);
            if (n == 800) do_reset("rand_reset");
            else tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
